vfifo_sync_ctrl: RTL and testbench
==================================

VFIFO_SYNC_CTRL -- requirements
Module: vfifo_sync_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 9; depth DEPTH = 2**ADDR_WIDTH words.
REQ-003 Parameter AFULL_LVL, default DEPTH-2; almost_full threshold.
REQ-004 Parameter AEMPTY_LVL, default 2; almost_empty threshold.
REQ-005 clk  input  1  single clock; all state on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 wr_en  input  1  write request.
REQ-008 wr_data  input  DATA_WIDTH  write word.
REQ-009 rd_en  input  1  read request.
REQ-010 rd_data  output  DATA_WIDTH  read word; valid only while rd_valid=1.
REQ-011 rd_valid  output  1  rd_data carries the word of the read accepted the previous cycle.
REQ-012 full, empty  output  1 each  occupancy flags.
REQ-013 almost_full, almost_empty  output  1 each  threshold flags.
REQ-014 count  output  ADDR_WIDTH+1  stored words, 0..DEPTH.
REQ-015 overflow, underflow  output  1 each  single-cycle error pulses.

Function
REQ-016 Write accepted iff wr_en=1 and full=0; word stored at wr_ptr; wr_ptr increments modulo DEPTH.
REQ-017 Read accepted iff rd_en=1 and empty=0; RAM read issued at rd_ptr; rd_ptr increments modulo DEPTH.
REQ-018 Read latency is exactly 1 cycle: rd_valid=1 and rd_data valid in the cycle after acceptance, otherwise rd_valid=0.
REQ-019 Pointers are ADDR_WIDTH+1 bits (wrap bit); full = (addresses equal, wrap bits differ); empty = (pointers equal).
REQ-020 count: +1 on write only, -1 on read only, unchanged on both or neither; registered, never exceeds DEPTH or drops below 0.
REQ-021 full, empty, almost_* are registered, updated in the same cycle as count: almost_full = count>=AFULL_LVL, almost_empty = count<=AEMPTY_LVL.
REQ-022 A word written in cycle N is readable (empty=0) from cycle N+1; no write-to-read bypass.
REQ-023 Full: wr_en=1 rejected and data dropped, even if a read is accepted in the same cycle; overflow=1 for that cycle.
REQ-024 Empty: rd_en=1 rejected, rd_valid=0 next cycle, underflow=1 in the request cycle; a write in the same cycle is accepted.
REQ-025 Simultaneous accepted read and write when 0<count<DEPTH: both proceed, flags unchanged.
REQ-026 Rejected requests change neither pointers nor count.
REQ-027 Pointer wrap from DEPTH-1 to 0 is seamless: data order preserved across wrap.

Reset
REQ-028 rst=1 at a clock edge: pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, rd_valid=0, overflow=0, underflow=0.
REQ-029 rst has priority over wr_en/rd_en in the same cycle; requests during reset are ignored and raise no error pulses.
REQ-030 Reset mid-operation discards stored words and any in-flight read: rd_valid=0 in the cycle after the reset edge.
REQ-031 rd_data and RAM contents are not reset.

Structure
REQ-032 Storage is one instance of vfifo_dual_port_ram_sc_sw (single clock, port A write, port B registered read), the sole sub-module.
REQ-033 Package vfifo_pkg holds the default DATA_WIDTH/ADDR_WIDTH constants and the count-width (ADDR_WIDTH+1) definition, shared with other vfifo blocks.
REQ-034 The controller holds no RAM array of its own; at most one read and one write are issued per cycle.

Verification (DATA_WIDTH=8, ADDR_WIDTH=2, DEPTH=4, AFULL_LVL=3, AEMPTY_LVL=1)
REQ-035 Reset, then write 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1,2,3,4; almost_full at count=3; full=1 after 4th; empty=0 from cycle after 1st write.
REQ-036 At full, wr_en=1 with 0x55 -> overflow pulse; count stays 4; four reads return 0x11..0x44, each with rd_valid 1 cycle after rd_en; empty=1 after 4th.
REQ-037 At empty, rd_en=1 with wr_en=1 (0xA5) -> underflow pulse, no rd_valid next cycle, count=1; next read returns 0xA5.
REQ-038 Count=2, simultaneous read+write for 10 cycles with incrementing data -> count stays 2, output order strictly incrementing across pointer wrap.
REQ-039 Count=3 with read accepted, rst=1 next cycle -> rd_valid=0 after reset edge, count=0, empty=1, no error pulses.

Source files
------------

// File: rtl/vfifo_pkg.sv
// rtl/vfifo_pkg.sv - shared vfifo sizing constants and count-width helper
package vfifo_pkg;

  localparam int VFIFO_DATA_WIDTH = 8;
  localparam int VFIFO_ADDR_WIDTH = 9;

  // One extra bit so count can represent DEPTH itself.
  function automatic int vfifo_cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/vfifo_dual_port_ram_sc_sw.sv
// rtl/vfifo_dual_port_ram_sc_sw.sv - single-clock RAM, port A write, port B registered read
module vfifo_dual_port_ram_sc_sw
  import vfifo_pkg::*;
#(
  parameter int DATA_WIDTH = VFIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = VFIFO_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_a_we,
  input  logic [ADDR_WIDTH-1:0] i_a_addr,
  input  logic [DATA_WIDTH-1:0] i_a_data,
  input  logic                  i_b_re,
  input  logic [ADDR_WIDTH-1:0] i_b_addr,
  output logic [DATA_WIDTH-1:0] o_b_data
);

  logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_b_data;

  always_ff @(posedge i_clk) begin
    if (i_a_we) begin
      r_mem[i_a_addr] <= i_a_data;
    end
    if (i_b_re) begin
      r_b_data <= r_mem[i_b_addr];
    end
  end

  assign o_b_data = r_b_data;

endmodule

// File: rtl/vfifo_sync_ctrl.sv
// rtl/vfifo_sync_ctrl.sv - synchronous FIFO controller around a single-clock dual-port RAM
module vfifo_sync_ctrl
  import vfifo_pkg::*;
#(
  parameter int DATA_WIDTH = VFIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = VFIFO_ADDR_WIDTH,
  parameter int AFULL_LVL  = (2**ADDR_WIDTH) - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     wr_en,
  input  logic [DATA_WIDTH-1:0]                    wr_data,
  input  logic                                     rd_en,
  output logic [DATA_WIDTH-1:0]                    rd_data,
  output logic                                     rd_valid,
  output logic                                     full,
  output logic                                     empty,
  output logic                                     almost_full,
  output logic                                     almost_empty,
  output logic [vfifo_cnt_width(ADDR_WIDTH)-1:0]   count,
  output logic                                     overflow,
  output logic                                     underflow
);

  localparam int CW = vfifo_cnt_width(ADDR_WIDTH);
  localparam logic [CW-1:0] C_AFULL  = CW'(AFULL_LVL);
  localparam logic [CW-1:0] C_AEMPTY = CW'(AEMPTY_LVL);

  logic [CW-1:0] r_wr_ptr;
  logic [CW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_afull;
  logic          r_aempty;
  logic          r_rd_valid;

  logic          w_wr_acc;
  logic          w_rd_acc;
  logic [CW-1:0] w_wr_ptr_nxt;
  logic [CW-1:0] w_rd_ptr_nxt;
  logic [CW-1:0] w_count_nxt;
  logic          w_full_nxt;
  logic          w_empty_nxt;

  // Requests seen while rst is high must not touch the RAM or the pointers.
  always_comb begin
    w_wr_acc     = wr_en & ~r_full & ~rst;
    w_rd_acc     = rd_en & ~r_empty & ~rst;
    w_wr_ptr_nxt = r_wr_ptr + CW'(w_wr_acc);
    w_rd_ptr_nxt = r_rd_ptr + CW'(w_rd_acc);
    w_count_nxt  = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
    w_full_nxt  = (w_wr_ptr_nxt[ADDR_WIDTH-1:0] == w_rd_ptr_nxt[ADDR_WIDTH-1:0]) &&
                  (w_wr_ptr_nxt[ADDR_WIDTH] != w_rd_ptr_nxt[ADDR_WIDTH]);
    w_empty_nxt = (w_wr_ptr_nxt == w_rd_ptr_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_afull    <= 1'b0;
      r_aempty   <= 1'b1;
      r_rd_valid <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_count    <= w_count_nxt;
      r_full     <= w_full_nxt;
      r_empty    <= w_empty_nxt;
      r_afull    <= (w_count_nxt >= C_AFULL);
      r_aempty   <= (w_count_nxt <= C_AEMPTY);
      r_rd_valid <= w_rd_acc;
    end
  end

  vfifo_dual_port_ram_sc_sw #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .i_clk    (clk),
    .i_a_we   (w_wr_acc),
    .i_a_addr (r_wr_ptr[ADDR_WIDTH-1:0]),
    .i_a_data (wr_data),
    .i_b_re   (w_rd_acc),
    .i_b_addr (r_rd_ptr[ADDR_WIDTH-1:0]),
    .o_b_data (rd_data)
  );

  // Error pulses flag the request cycle itself, so they are combinational.
  assign overflow     = ~rst & wr_en & r_full;
  assign underflow    = ~rst & rd_en & r_empty;
  assign rd_valid     = r_rd_valid;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign count        = r_count;

endmodule

// File: tb/tb_vfifo_sync_ctrl.sv
// tb/tb_vfifo_sync_ctrl.sv - scoreboard bench for vfifo_sync_ctrl at depth 4
module tb_vfifo_sync_ctrl;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DEPTH = 4;
  localparam int AFL = 3;
  localparam int AEL = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int fails  = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];
  logic          exp_rv = 1'b0;

  vfifo_sync_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .AFULL_LVL  (AFL),
    .AEMPTY_LVL (AEL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check request-cycle pulses, update model, check registered state.
  task automatic cyc(input logic r_st, input logic w, input logic [DW-1:0] d, input logic r);
    int  mcnt;
    logic wacc, racc;
    @(negedge clk);
    rst = r_st; wr_en = w; wr_data = d; rd_en = r;
    #1;
    mcnt = model_q.size();
    chk("overflow", {31'b0, overflow}, {31'b0, (!r_st && w && mcnt == DEPTH)});
    chk("underflow", {31'b0, underflow}, {31'b0, (!r_st && r && mcnt == 0)});
    wacc = !r_st && w && mcnt != DEPTH;
    racc = !r_st && r && mcnt != 0;
    if (r_st) begin
      model_q.delete();
      exp_q.delete();
    end else begin
      if (racc) exp_q.push_back(model_q.pop_front());
      if (wacc) model_q.push_back(d);
    end
    exp_rv = racc;
    mcnt = model_q.size();
    @(posedge clk);
    #1;
    chk("count", {29'b0, count}, mcnt);
    chk("full", {31'b0, full}, {31'b0, mcnt == DEPTH});
    chk("empty", {31'b0, empty}, {31'b0, mcnt == 0});
    chk("almost_full", {31'b0, almost_full}, {31'b0, mcnt >= AFL});
    chk("almost_empty", {31'b0, almost_empty}, {31'b0, mcnt <= AEL});
    chk("rd_valid", {31'b0, rd_valid}, {31'b0, exp_rv});
    if (exp_rv && exp_q.size() > 0) begin
      chk("rd_data", {24'b0, rd_data}, {24'b0, exp_q.pop_front()});
    end
  endtask

  initial begin
    cyc(1, 0, 8'h00, 0);
    cyc(1, 1, 8'h99, 1);
    // fill to full
    cyc(0, 1, 8'h11, 0);
    cyc(0, 1, 8'h22, 0);
    cyc(0, 1, 8'h33, 0);
    cyc(0, 1, 8'h44, 0);
    cyc(0, 1, 8'h55, 0);
    // drain
    for (int i = 0; i < 4; i++) cyc(0, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 0);
    // underflow with simultaneous write
    cyc(0, 1, 8'hA5, 1);
    cyc(0, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 0);
    // steady state at count 2 across pointer wrap
    cyc(0, 1, 8'h01, 0);
    cyc(0, 1, 8'h02, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 8'(i + 3), 1);
    // count 3, read accepted, then reset
    cyc(0, 1, 8'h0D, 0);
    cyc(0, 0, 8'h00, 1);
    cyc(1, 1, 8'hEE, 1);
    cyc(0, 0, 8'h00, 0);
    // full with simultaneous read: write dropped, read proceeds
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'(8'hC0 + i), 0);
    cyc(0, 1, 8'h66, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 0);
    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
